// File: rtl/dyser_cfg_seq.sv
// -----------------------------------------------------------------------------
// dyser_cfg_seq
// Configuration sequencer for the DySER fabric. The host loads an image of
// NUM_WORDS configuration words into a small local RAM. A start request then
// streams that image into the fabric one word per cycle through
// config_bits_o/config_en_o. While the fabric is being reconfigured,
// send_gate_o blocks dyser_send traffic upstream. Completion, abort and host
// misuse are reported back to the host.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          asynchronous active-high reset
//   img_wr_en_i    write one image word
//   img_wr_addr_i  image word index
//   img_wr_data_i  image word data
//   start_i        begin streaming the image
//   abort_i        cancel an in-progress sequence
//   hold_i         stall streaming for this cycle
//   clr_err_i      clear the sticky error flag
//   config_bits_o  registered word to the fabric
//   config_en_o    registered valid for config_bits_o
//   busy_o         high while streaming or draining
//   send_gate_o    copy of busy_o, gates dyser_send traffic
//   done_o         one-cycle pulse on normal completion
//   aborted_o      one-cycle pulse when an abort is taken
//   err_o          sticky misuse flag
//   word_idx_o     index of the next word to stream
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dyser_cfg_seq #(
  parameter int CFG_WIDTH = 21,
  parameter int NUM_WORDS = 17,
  parameter int ADDR_W    = 5,
  parameter int DRAIN_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 img_wr_en_i,
  input  logic [ADDR_W-1:0]    img_wr_addr_i,
  input  logic [CFG_WIDTH-1:0] img_wr_data_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 hold_i,
  input  logic                 clr_err_i,
  output logic [CFG_WIDTH-1:0] config_bits_o,
  output logic                 config_en_o,
  output logic                 busy_o,
  output logic                 send_gate_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic                 err_o,
  output logic [ADDR_W-1:0]    word_idx_o
);

  localparam int DCW = $clog2(DRAIN_CYC + 2);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   WORDS_EXT  = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      word_idx_q, word_idx_d;
  logic [CFG_WIDTH-1:0]   config_bits_q, config_bits_d;
  logic                   config_en_q, config_en_d;
  logic                   aborted_q, aborted_d;
  logic                   err_q, err_d;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [CFG_WIDTH-1:0]   image_q [NUM_WORDS];

  logic busy;
  logic addr_ok;
  logic wr_ok;
  logic err_set;

  assign busy    = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign addr_ok = {1'b0, img_wr_addr_i} < WORDS_EXT;
  assign wr_ok   = img_wr_en_i && !busy && addr_ok;

  // Misuse: a start the sequencer cannot honour, or a write that would either
  // corrupt the image mid-stream or land outside it. Such requests are dropped.
  assign err_set = (start_i && (busy || (state_q == ST_FIN))) ||
                   (img_wr_en_i && (busy || !addr_ok));

  // Image RAM. Deliberately not reset so it maps onto plain storage; the
  // host must load it before the first start.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      image_q[img_wr_addr_i] <= img_wr_data_i;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      word_idx_q    <= '0;
      config_bits_q <= '0;
      config_en_q   <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      config_bits_q <= config_bits_d;
      config_en_q   <= config_en_d;
      aborted_q     <= aborted_d;
      err_q         <= err_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  // Next-state logic. The DRAIN state is entered on the edge that issues the
  // last word, so its first cycle still shows that word on config_en; the
  // counter therefore runs 0..DRAIN_CYC to give DRAIN_CYC quiet cycles.
  always_comb begin
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    config_bits_d = config_bits_q;
    config_en_d   = 1'b0;
    aborted_d     = 1'b0;
    drain_cnt_d   = drain_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d    = ST_STREAM;
          word_idx_d = '0;
        end
      end

      ST_STREAM: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          word_idx_d = '0;
          aborted_d  = 1'b1;
        end else if (!hold_i) begin
          config_en_d   = 1'b1;
          config_bits_d = image_q[word_idx_q];
          word_idx_d    = word_idx_q + 1'b1;
          if (word_idx_q == LAST_IDX) begin
            drain_cnt_d = '0;
            if (DRAIN_CYC == 0) begin
              state_d    = ST_FIN;
              word_idx_d = '0;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          word_idx_d = '0;
          aborted_d  = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d    = ST_FIN;
          word_idx_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      ST_FIN: begin
        state_d    = ST_IDLE;
        word_idx_d = '0;
      end

      default: begin
        state_d    = ST_IDLE;
        word_idx_d = '0;
      end
    endcase

    // A new misuse event outranks a simultaneous clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (clr_err_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign config_bits_o = config_bits_q;
  assign config_en_o   = config_en_q;
  assign busy_o        = busy;
  assign send_gate_o   = busy;
  assign done_o        = (state_q == ST_FIN);
  assign aborted_o     = aborted_q;
  assign err_o         = err_q;
  assign word_idx_o    = word_idx_q;

endmodule

// File: tb/tb_dyser_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_dyser_cfg_seq
// Scoreboard bench for dyser_cfg_seq. Stimulus tasks push the expected
// word/done/abort events, each stamped with the cycle it must appear in; a
// separate monitor pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dyser_cfg_seq;

  localparam int CW = 21;
  localparam int NW = 17;
  localparam int AW = 5;
  localparam int DC = 2;

  localparam int K_WORD  = 1;
  localparam int K_DONE  = 2;
  localparam int K_ABORT = 3;

  typedef struct {
    int            kind;
    logic [CW-1:0] data;
    int            cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imgWrEn;
  logic [AW-1:0] imgWrAddr;
  logic [CW-1:0] imgWrData;
  logic          start;
  logic          abort;
  logic          hold;
  logic          clrErr;
  logic [CW-1:0] configBits;
  logic          configEn;
  logic          busy;
  logic          sendGate;
  logic          done;
  logic          aborted;
  logic          err;
  logic [AW-1:0] wordIdx;

  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            startEdge = 0;
  ev_t           expQ[$];
  logic [CW-1:0] img [NW];

  dyser_cfg_seq #(
    .CFG_WIDTH(CW), .NUM_WORDS(NW), .ADDR_W(AW), .DRAIN_CYC(DC)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .img_wr_en_i(imgWrEn), .img_wr_addr_i(imgWrAddr), .img_wr_data_i(imgWrData),
    .start_i(start), .abort_i(abort), .hold_i(hold), .clr_err_i(clrErr),
    .config_bits_o(configBits), .config_en_o(configEn),
    .busy_o(busy), .send_gate_o(sendGate), .done_o(done),
    .aborted_o(aborted), .err_o(err), .word_idx_o(wordIdx)
  );

  // Free-running clock and edge counter; cyc equals k after edge k.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input logic [CW-1:0] data, input int when);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = when;
    expQ.push_back(e);
  endtask

  task automatic matchEvent(input int kind, input logic [CW-1:0] data);
    if (expQ.size() == 0) begin
      checkOutput("unexpected_event", 32'(kind), 32'(0));
    end else begin
      checkOutput("event_kind", 32'(kind), 32'(expQ[0].kind));
      checkOutput("event_cycle", 32'(cyc), 32'(expQ[0].cyc));
      if (kind == K_WORD) checkOutput("config_bits", 32'(data), 32'(expQ[0].data));
      if (expQ[0].cyc <= cyc) void'(expQ.pop_front());
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        checkOutput("missing_event", 32'(cyc), 32'(expQ[0].cyc));
        void'(expQ.pop_front());
      end
      if (configEn) matchEvent(K_WORD, configBits);
      if (done)     matchEvent(K_DONE, '0);
      if (aborted)  matchEvent(K_ABORT, '0);
    end
  end

  // Drives one cycle of control inputs starting at a falling edge.
  task automatic applyStimulus(input logic st, input logic ab, input logic ce,
                               input logic we, input logic [AW-1:0] addr,
                               input logic [CW-1:0] data);
    start     = st;
    abort     = ab;
    clrErr    = ce;
    imgWrEn   = we;
    imgWrAddr = addr;
    imgWrData = data;
    @(negedge clk);
    start   = 1'b0;
    abort   = 1'b0;
    clrErr  = 1'b0;
    imgWrEn = 1'b0;
  endtask

  // Starts a full sequence, optionally with a hold burst beginning at word
  // holdStart. Returns one cycle after done so a new start may follow.
  task automatic runStream(input int holdStart, input int holdLen);
    int k;
    int endCyc;
    k = cyc + 1;
    startEdge = k;
    for (int i = 0; i < NW; i++)
      pushEv(K_WORD, img[i], k + 1 + i + ((holdLen > 0 && i >= holdStart) ? holdLen : 0));
    pushEv(K_DONE, '0, k + NW + DC + 1 + holdLen);
    endCyc = k + NW + DC + 2 + holdLen;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    while (cyc < endCyc) begin
      hold = (holdLen > 0) && (cyc >= k + holdStart) && (cyc < k + holdStart + holdLen);
      checkOutput("busy", 32'(busy), 32'(cyc <= k + NW + DC + holdLen));
      checkOutput("send_gate", 32'(sendGate), 32'(cyc <= k + NW + DC + holdLen));
      @(negedge clk);
    end
    hold = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    imgWrEn = 1'b0; imgWrAddr = '0; imgWrData = '0;
    start = 1'b0; abort = 1'b0; hold = 1'b0; clrErr = 1'b0;

    for (int i = 0; i < NW; i++) img[i] = CW'((i + 1) * 32'h1111);
    img[2]  = 21'h001800;
    img[7]  = 21'h080040;
    img[13] = 21'h108002;
    img[16] = 21'h000002;

    repeat (2) @(negedge clk);
    checkOutput("rst_config_en", 32'(configEn), 32'(0));
    checkOutput("rst_config_bits", 32'(configBits), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_aborted", 32'(aborted), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    checkOutput("rst_word_idx", 32'(wordIdx), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] T1 load image and stream");
    for (int i = 0; i < NW; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, AW'(i), img[i]);
    checkOutput("err_after_load", 32'(err), 32'(0));
    runStream(0, 0);

    $display("[TB] T5 back-to-back restart");
    runStream(0, 0);

    $display("[TB] T2 hold burst at word 5");
    repeat (2) @(negedge clk);
    runStream(5, 3);

    $display("[TB] T3 abort at word 8");
    repeat (2) @(negedge clk);
    k = cyc + 1;
    for (int i = 0; i < 8; i++) pushEv(K_WORD, img[i], k + 1 + i);
    pushEv(K_ABORT, '0, k + 9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    while (cyc < k + 8) @(negedge clk);
    checkOutput("word_idx_before_abort", 32'(wordIdx), 32'(8));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("config_en_after_abort", 32'(configEn), 32'(0));
    checkOutput("busy_after_abort", 32'(busy), 32'(0));
    checkOutput("word_idx_after_abort", 32'(wordIdx), 32'(0));
    repeat (25) @(negedge clk);
    runStream(0, 0);

    $display("[TB] T4 misuse");
    repeat (2) @(negedge clk);
    fork
      runStream(0, 0);
      begin
        @(negedge clk);
        while (cyc < startEdge + 3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("err_start_busy", 32'(err), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        checkOutput("err_cleared", 32'(err), 32'(0));
        while (cyc < startEdge + 18) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, AW'(3), 21'h1FFFFF);
        checkOutput("err_write_drain", 32'(err), 32'(1));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        checkOutput("err_cleared_fin", 32'(err), 32'(0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("err_start_fin", 32'(err), 32'(1));
        checkOutput("busy_start_fin", 32'(busy), 32'(0));
      end
    join
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("err_cleared2", 32'(err), 32'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, AW'(20), 21'h0ABCDE);
    checkOutput("err_bad_addr", 32'(err), 32'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("err_cleared3", 32'(err), 32'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, AW'(20), 21'h0ABCDE);
    checkOutput("err_set_beats_clr", 32'(err), 32'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("err_cleared4", 32'(err), 32'(0));
    runStream(0, 0);

    $display("[TB] T6 async reset at word 10");
    repeat (2) @(negedge clk);
    k = cyc + 1;
    for (int i = 0; i < 10; i++) pushEv(K_WORD, img[i], k + 1 + i);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    while (cyc < k + 10) @(negedge clk);
    checkOutput("word_idx_before_rst", 32'(wordIdx), 32'(10));
    #2 rst = 1'b1;
    #1;
    checkOutput("async_config_en", 32'(configEn), 32'(0));
    checkOutput("async_config_bits", 32'(configBits), 32'(0));
    checkOutput("async_busy", 32'(busy), 32'(0));
    checkOutput("async_word_idx", 32'(wordIdx), 32'(0));
    checkOutput("async_done", 32'(done), 32'(0));
    checkOutput("async_aborted", 32'(aborted), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    runStream(0, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
